usr_seq: RTL and testbench

Frame sequencer that sits directly upstream of the 4-bit universal shift register (USR) and drives its `sel`, `pi` and `si` inputs. It accepts a parallel word through a valid/ready handshake, issues one parallel-load cycle, then issues shift commands so the word leaves the USR serially, MSB-first or LSB-first, one bit per clock. It flags the cycles in which the USR's serial tap carries a valid bit and pulses `done` when the frame completes.

---
 rtl/usr_seq.sv | 108 ++++++++++
 tb/tb_usr_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usr_seq.sv
// Frame sequencer for a WIDTH-bit universal shift register: parallel-loads a
// handshaken word, then shifts it out serially MSB- or LSB-first.
module usr_seq #(
  parameter int   WIDTH = 4,
  parameter logic FILL  = 1'b0,
  localparam int  CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_lsb_first,
  input  logic             abort,
  output logic             in_ready,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] pi,
  output logic             si,
  output logic             frame,
  output logic [CW-1:0]    bit_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             lsb_q, lsb_d;

  always_comb begin
    // NOTE: every _d starts at its _q value so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    lsb_d   = lsb_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          word_d  = in_data;
          lsb_d   = in_lsb_first;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = abort ? S_IDLE : S_SHIFT;
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the latched word is reset too, because pi must read 0 out of reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      lsb_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values of the others.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      lsb_q   <= lsb_d;
    end
  end

  // Moore decode: outputs depend on registered state only, never on inputs.
  always_comb begin
    in_ready = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
    frame    = (state_q == S_SHIFT);
    done     = (state_q == S_DONE);
    bit_idx  = frame ? cnt_q : '0;
    pi       = word_q;
    si       = FILL;
    sel      = SEL_HOLD;
    case (state_q)
      S_LOAD:  sel = SEL_LOAD;
      S_SHIFT: begin
        // The final bit is already on the tap, so the USR is held from there on.
        if (cnt_q != CNT_LAST) sel = lsb_q ? SEL_RIGHT : SEL_LEFT;
      end
      default: sel = SEL_HOLD;
    endcase
  end

endmodule

// File: tb/tb_usr_seq.sv
// Bench for usr_seq: directed test-plan frames plus randomized traffic checked
// every cycle against a frame-phase model and an attached USR model.
module tb_usr_seq;

  localparam int W  = 4;
  localparam int CW = $clog2(W);

  logic         clk, clr;
  logic         in_valid, in_lsb_first, abort;
  logic [W-1:0] in_data;
  logic         in_ready, si, frame, busy, done;
  logic [1:0]   sel;
  logic [W-1:0] pi;
  logic [CW-1:0] bit_idx;

  logic         f_valid, f_lsb, f_abort;
  logic [W-1:0] f_data;
  logic         f_in_ready, f_si, f_frame, f_busy, f_done;
  logic [1:0]   f_sel;
  logic [W-1:0] f_pi;
  logic [CW-1:0] f_bit_idx;

  int errors = 0;
  int checks = 0;
  bit run_cmp = 0;

  usr_seq #(.WIDTH(W), .FILL(1'b0)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_lsb_first(in_lsb_first), .abort(abort), .in_ready(in_ready),
    .sel(sel), .pi(pi), .si(si), .frame(frame), .bit_idx(bit_idx),
    .busy(busy), .done(done)
  );

  usr_seq #(.WIDTH(W), .FILL(1'b1)) dut_f (
    .clk(clk), .clr(clr), .in_valid(f_valid), .in_data(f_data),
    .in_lsb_first(f_lsb), .abort(f_abort), .in_ready(f_in_ready),
    .sel(f_sel), .pi(f_pi), .si(f_si), .frame(f_frame), .bit_idx(f_bit_idx),
    .busy(f_busy), .done(f_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Attached USR models, driven by each sequencer's sel/pi/si.
  logic [W-1:0] usr, usr_f;
  function automatic logic [W-1:0] usr_next(input logic [W-1:0] cur, input logic [1:0] s,
                                            input logic [W-1:0] p, input logic sin);
    case (s)
      2'b11:   return p;
      2'b10:   return {cur[W-2:0], sin};
      2'b01:   return {sin, cur[W-1:1]};
      default: return cur;
    endcase
  endfunction
  always @(posedge clk) begin
    usr   <= usr_next(usr, sel, pi, si);
    usr_f <= usr_next(usr_f, f_sel, f_pi, f_si);
  end

  // Frame model: phase 0 idle, 1 load, 2..W+1 bit (phase-2) on tap, W+2 done.
  int           m_p;
  logic [W-1:0] m_word;
  logic         m_lsb;
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_p = 0; m_word = '0; m_lsb = 1'b0;
    end else if (m_p == 0) begin
      if (in_valid) begin
        m_p = 1; m_word = in_data; m_lsb = in_lsb_first;
      end
    end else if (abort || m_p == W + 2) begin
      m_p = 0;
    end else begin
      m_p = m_p + 1;
    end
  end

  always @(negedge clk) begin
    if (run_cmp && !clr) begin
      bit in_frame;
      int k;
      logic [1:0] e_sel;
      in_frame = (m_p >= 2) && (m_p <= W + 1);
      k = m_p - 2;
      if (m_p == 1) e_sel = 2'b11;
      else if (in_frame && k < W - 1) e_sel = m_lsb ? 2'b01 : 2'b10;
      else e_sel = 2'b00;
      check("in_ready", in_ready, m_p == 0);
      check("busy", busy, m_p != 0);
      check("frame", frame, in_frame);
      check("done", done, m_p == W + 2);
      check("sel", sel, e_sel);
      check("pi", pi, m_word);
      check("si", si, 0);
      if (in_frame) begin
        check("bit_idx", bit_idx, k);
        check("tap", m_lsb ? usr[0] : usr[W-1], m_lsb ? m_word[k] : m_word[W-1-k]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check("idle_timeout", in_ready, 1);
  endtask

  // Presents a word for one handshake; returns in cycle T+1.
  task automatic start(input logic [W-1:0] d, input logic lsb);
    in_valid = 1'b1; in_data = d; in_lsb_first = lsb;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_sel [7];
    logic       exp_tap [4];
    logic [W-1:0] got;

    clr = 1'b1; in_valid = 0; in_data = '0; in_lsb_first = 0; abort = 0;
    f_valid = 0; f_data = '0; f_lsb = 0; f_abort = 0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_sel", sel, 0);
    check("rst_pi", pi, 0);
    check("rst_busy", busy, 0);
    check("rst_frame", frame, 0);
    check("rst_done", done, 0);
    step();
    clr = 1'b0;
    run_cmp = 1;
    step();

    // MSB-first 1011: literal sel/tap/done/in_ready sequence from T+1.
    exp_sel = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    exp_tap = '{1'b1, 1'b0, 1'b1, 1'b1};
    start(4'b1011, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      check("msb_sel", sel, exp_sel[c-1]);
      if (c >= 2 && c <= 5) begin
        check("msb_tap", usr[W-1], exp_tap[c-2]);
        check("msb_frame", frame, 1);
      end
      check("msb_done", done, c == 6);
      step();
    end
    check("msb_ready_t7", in_ready, 1);

    // LSB-first 1011.
    exp_tap = '{1'b1, 1'b1, 1'b0, 1'b1};
    start(4'b1011, 1'b1);
    step();
    for (int k = 0; k < 4; k++) begin
      check("lsb_sel", sel, k < 3 ? 2'b01 : 2'b00);
      check("lsb_tap", usr[0], exp_tap[k]);
      check("lsb_bit_idx", bit_idx, k);
      step();
    end
    wait_idle();

    // Back-to-back with in_valid held high: A then 5.
    in_valid = 1'b1; in_data = 4'hA; in_lsb_first = 1'b0;
    step();
    in_data = 4'h5;
    step(); step();
    check("b2b_pi_busy", pi, 4'hA);
    step(); step(); step();
    check("b2b_done_t6", done, 1);
    check("b2b_ready_t6", in_ready, 0);
    step();
    check("b2b_ready_t7", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("b2b_sel_t8", sel, 2'b11);
    check("b2b_pi_t8", pi, 4'h5);
    wait_idle();

    // Abort at T+3.
    start(4'hC, 1'b0);
    step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_sel", sel, 0);
    check("abort_ready", in_ready, 1);
    check("abort_frame", frame, 0);
    for (int c = 0; c < 4; c++) begin
      check("abort_no_done", done, 0);
      step();
    end

    // Asynchronous clr mid-SHIFT, then a fresh LSB-first 0110 frame.
    start(4'h9, 1'b0);
    step(); step();
    #1 clr = 1'b1;
    #1;
    check("clr_in_ready", in_ready, 1);
    check("clr_sel", sel, 0);
    check("clr_pi", pi, 0);
    check("clr_frame", frame, 0);
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    check("clr_bit_idx", bit_idx, 0);
    step();
    clr = 1'b0;
    step();
    start(4'h6, 1'b1);
    step();
    got = '0;
    for (int k = 0; k < 4; k++) begin
      got[k] = usr[0];
      step();
    end
    check("post_clr_word", got, 4'h6);
    wait_idle();

    // FILL=1 instance, word 0 MSB-first.
    f_valid = 1'b1; f_data = 4'h0; f_lsb = 1'b0;
    step();
    f_valid = 1'b0;
    for (int c = 0; c < 6; c++) step();
    check("fill_usr_final", usr_f, 4'b0111);
    check("fill_ready", f_in_ready, 1);

    // Randomized traffic, checked by the per-cycle compare process.
    for (int c = 0; c < 600; c++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_data      = W'($urandom);
      in_lsb_first = 1'($urandom);
      abort        = ($urandom_range(0, 19) == 0);
      step();
    end
    in_valid = 0; abort = 0;
    wait_idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
